// File: rtl/multi_digit_seven_segment_driver.sv
// Time-multiplexed common-anode seven-segment driver for 1..8 digits.
// Scans one digit per dwell period, decodes hex/decimal glyphs, applies
// decimal points, leading-zero blanking and PWM dimming. Inputs are
// shadowed once per frame so a scan never shows a half-updated value.
module multi_digit_seven_segment_driver #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned DIGIT_HZ    = 250,
    parameter int unsigned BRIGHT_BITS = 3
) (
    input  logic                     clk_100MHz,
    input  logic                     rst,
    input  logic [4*DIGITS-1:0]      values,
    input  logic [DIGITS-1:0]        digits_en,
    input  logic [DIGITS-1:0]        dots,
    input  logic                     decimal,
    input  logic                     blank_leading,
    input  logic [BRIGHT_BITS-1:0]   brightness,
    output logic [DIGITS-1:0]        anodes,
    output logic [7:0]               cathodes,
    output logic                     frame_tick
);

    localparam int unsigned DWELL = CLK_HZ / DIGIT_HZ;
    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [BRIGHT_BITS-1:0] pwm_q, pwm_d;
    logic                   tick;
    logic                   last_digit;

    logic [4*DIGITS-1:0]    sh_values_q;
    logic [DIGITS-1:0]      sh_en_q;
    logic [DIGITS-1:0]      sh_dots_q;
    logic                   sh_decimal_q;
    logic                   sh_blank_q;

    logic [DIGITS-1:0]      lead_blank;
    logic                   zero_above;

    logic [3:0]             cur_val;
    logic                   cur_en;
    logic                   cur_dot;
    logic                   cur_blank;
    logic                   visible;

    logic [DIGITS-1:0]      anodes_q, anodes_d;
    logic [7:0]             cathodes_q, cathodes_d;
    logic                   frame_tick_q, frame_tick_d;

    // Active-low glyph (bit0 = CA); decimal mode shows '-' for 10..15.
    function automatic logic [6:0] glyph(input logic [3:0] v, input logic dec);
        logic [6:0] g;
        case (v)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        if (dec && (v > 4'h9)) begin
            g = 7'b0111111;
        end
        return g;
    endfunction

    // Dwell counter, digit index and PWM phase next-state.
    always_comb begin
        tick         = (cnt_q == CNT_W'(DWELL - 1));
        last_digit   = (idx_q == IDX_W'(DIGITS - 1));
        cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        if (tick) begin
            idx_d = last_digit ? '0 : idx_q + IDX_W'(1);
        end
        pwm_d        = pwm_q + BRIGHT_BITS'(1);
        frame_tick_d = tick && last_digit;
    end

    // Scan state registers.
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
            pwm_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            pwm_q <= pwm_d;
        end
    end

    // Frame-synchronous input capture, on the same edge the index wraps to 0.
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            sh_values_q  <= '0;
            sh_en_q      <= '0;
            sh_dots_q    <= '0;
            sh_decimal_q <= 1'b0;
            sh_blank_q   <= 1'b0;
        end else if (frame_tick_d) begin
            sh_values_q  <= values;
            sh_en_q      <= digits_en;
            sh_dots_q    <= dots;
            sh_decimal_q <= decimal;
            sh_blank_q   <= blank_leading;
        end
    end

    // Digit i>0 is a leading zero when it and every higher digit are zero.
    always_comb begin
        lead_blank = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above    = zero_above && (sh_values_q[4*i +: 4] == 4'h0);
            lead_blank[i] = sh_blank_q && zero_above;
        end
    end

    // Select the current digit's shadowed attributes.
    always_comb begin
        cur_val   = 4'h0;
        cur_en    = 1'b0;
        cur_dot   = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == idx_q) begin
                cur_val   = sh_values_q[4*i +: 4];
                cur_en    = sh_en_q[i];
                cur_dot   = sh_dots_q[i];
                cur_blank = lead_blank[i];
            end
        end
    end

    // Output drive for the current digit; dark unless enabled, not blanked and in PWM on-phase.
    always_comb begin
        anodes_d   = '1;
        cathodes_d = 8'hFF;
        visible    = cur_en && !cur_blank && (pwm_q <= brightness);
        if (visible) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (IDX_W'(i) == idx_q) begin
                    anodes_d[i] = 1'b0;
                end
            end
            cathodes_d = {~cur_dot, glyph(cur_val, sh_decimal_q)};
        end
    end

    // Registered pin outputs.
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            anodes_q     <= '1;
            cathodes_q   <= 8'hFF;
            frame_tick_q <= 1'b0;
        end else begin
            anodes_q     <= anodes_d;
            cathodes_q   <= cathodes_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign anodes     = anodes_q;
    assign cathodes   = cathodes_q;
    assign frame_tick = frame_tick_q;

endmodule
